// File: rtl/nn_seq_ctrl_if.sv
// Host-load and datapath-control bundle for nn_seq_ctrl.
// master = host/datapath side, slave = the sequencer.
interface nn_seq_ctrl_if #(
  parameter int AW = 8
);
  logic          start;
  logic          in_valid;
  logic [AW-1:0] count;
  logic          feat_we;
  logic [AW-1:0] feat_addr;
  logic          mac_en;
  logic          acc_clr;
  logic          neuron_done;
  logic [6:0]    neuron_idx;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, in_valid, count,
    input  feat_we, feat_addr, mac_en, acc_clr, neuron_done, neuron_idx, busy, done, err
  );

  modport slave (
    input  start, in_valid, count,
    output feat_we, feat_addr, mac_en, acc_clr, neuron_done, neuron_idx, busy, done, err
  );
endinterface

// File: rtl/nn_seq_ctrl.sv
// nn_seq_ctrl: loads NIN feature words, then streams NNEU neurons x NIN weight beats to the MAC array.
// Define NN_SEQ_STRICT_IDX_EN to check the host beat index against the internal pointer.
module nn_seq_ctrl #(
  parameter int NIN   = 50,
  parameter int NNEU  = 100,
  parameter int DRAIN = 3,
  parameter int AW    = 8
) (
  input logic          clock,
  input logic          reset,
  nn_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IN = 3'd1,
    S_LOAD_W  = 3'd2,
    S_FLUSH   = 3'd3,
    S_NDONE   = 3'd4,
    S_CLR     = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(NIN - 1);
  localparam logic [AW-1:0] DRAIN_LAST = AW'(DRAIN - 1);
  localparam logic [6:0]    NIDX_LAST  = 7'(NNEU - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] feat_addr_q, feat_addr_d;
  logic [6:0]    nidx_q, nidx_d;
  logic [6:0]    neuron_idx_q;
  logic          feat_we_q, feat_we_d;
  logic          rd_q, rd_d;
  logic          mac_en_q;
  logic          acc_clr_q, acc_clr_d;
  logic          ndone_q, ndone_d;
  logic          busy_q, done_q;
  logic          err_q, err_d;
  logic          drop_s;
  logic          idle_s;
  logic          idx_ok_s;

  assign idle_s = (state_q == S_IDLE) || (state_q == S_DONE);

`ifdef NN_SEQ_STRICT_IDX_EN
  // Feature beats are numbered from 0, weight beats from 1.
  always_comb begin
    if (state_q == S_LOAD_IN) begin
      idx_ok_s = (bus.count == ptr_q);
    end else begin
      idx_ok_s = (bus.count == (ptr_q + PTR_ONE));
    end
  end
`else
  assign idx_ok_s = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    nidx_d      = nidx_q;
    feat_addr_d = feat_addr_q;
    feat_we_d   = 1'b0;
    rd_d        = 1'b0;
    acc_clr_d   = 1'b0;
    ndone_d     = 1'b0;
    drop_s      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_LOAD_IN;
          ptr_d     = '0;
          nidx_d    = 7'd0;
          acc_clr_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD_IN, S_LOAD_W: begin
        if (bus.in_valid && idx_ok_s) begin
          feat_addr_d = ptr_q;
          feat_we_d   = (state_q == S_LOAD_IN);
          rd_d        = (state_q == S_LOAD_W);
          if (ptr_q == PTR_LAST) begin
            ptr_d   = '0;
            state_d = (state_q == S_LOAD_IN) ? S_LOAD_W : S_FLUSH;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end else begin
          drop_s = bus.in_valid;
        end
      end
      // ptr doubles as the drain counter while the MAC pipeline empties.
      S_FLUSH: begin
        drop_s = bus.in_valid;
        if (ptr_q == DRAIN_LAST) begin
          ptr_d   = '0;
          state_d = S_NDONE;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      S_NDONE: begin
        drop_s  = bus.in_valid;
        ndone_d = 1'b1;
        state_d = (nidx_q == NIDX_LAST) ? S_DONE : S_CLR;
      end
      S_CLR: begin
        drop_s    = bus.in_valid;
        acc_clr_d = 1'b1;
        nidx_d    = nidx_q + 7'd1;
        ptr_d     = '0;
        state_d   = S_LOAD_W;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (idle_s && bus.start) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | drop_s | (bus.start & ~idle_s);
    end
  end

  // State, counters and registered outputs; mac_en trails the read address by the RAM latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      nidx_q       <= 7'd0;
      feat_addr_q  <= '0;
      feat_we_q    <= 1'b0;
      rd_q         <= 1'b0;
      mac_en_q     <= 1'b0;
      acc_clr_q    <= 1'b0;
      ndone_q      <= 1'b0;
      neuron_idx_q <= 7'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      nidx_q       <= nidx_d;
      feat_addr_q  <= feat_addr_d;
      feat_we_q    <= feat_we_d;
      rd_q         <= rd_d;
      mac_en_q     <= rd_q;
      acc_clr_q    <= acc_clr_d;
      ndone_q      <= ndone_d;
      neuron_idx_q <= nidx_q;
      busy_q       <= !((state_d == S_IDLE) || (state_d == S_DONE));
      done_q       <= (state_d == S_DONE);
      err_q        <= err_d;
    end
  end

  assign bus.feat_we     = feat_we_q;
  assign bus.feat_addr   = feat_addr_q;
  assign bus.mac_en      = mac_en_q;
  assign bus.acc_clr     = acc_clr_q;
  assign bus.neuron_done = ndone_q;
  assign bus.neuron_idx  = neuron_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Scoreboard bench for nn_seq_ctrl: randomized host beats, expected events queued by a timing model.
// Builds with or without NN_SEQ_STRICT_IDX_EN.
module tb_nn_seq_ctrl;
  localparam int NIN   = 50;
  localparam int NNEU  = 100;
  localparam int DRAIN = 3;
  localparam int AW    = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  typedef struct {
    int e;
    int v;
  } ev_t;

  ev_t q_we[$];
  ev_t q_mac[$];
  ev_t q_nd[$];
  ev_t q_clr[$];

  nn_seq_ctrl_if #(.AW(AW)) bus ();

  nn_seq_ctrl #(.NIN(NIN), .NNEU(NNEU), .DRAIN(DRAIN), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic match(input string nm, input int have, input ev_t ev, input int act_v);
    if (have == 0) begin
      chk({nm, "_unexpected"}, 1, 0);
    end else begin
      chk({nm, "_cycle"}, cyc, ev.e);
      chk({nm, "_value"}, act_v, ev.v);
    end
  endtask

  // Monitor: each output strobe pops its queue; mac_en is checked against the address one cycle earlier.
  initial begin
    int  prev_addr;
    int  have;
    ev_t ev;
    prev_addr = 0;
    forever begin
      @(negedge clock);
      if (!reset && mon_en) begin
        if (bus.feat_we === 1'b1) begin
          have = q_we.size(); ev.e = 0; ev.v = 0;
          if (have > 0) ev = q_we.pop_front();
          match("feat_we", have, ev, int'(bus.feat_addr));
        end
        if (bus.mac_en === 1'b1) begin
          have = q_mac.size(); ev.e = 0; ev.v = 0;
          if (have > 0) ev = q_mac.pop_front();
          match("mac_en", have, ev, prev_addr);
        end
        if (bus.neuron_done === 1'b1) begin
          have = q_nd.size(); ev.e = 0; ev.v = 0;
          if (have > 0) ev = q_nd.pop_front();
          match("neuron_done", have, ev, int'(bus.neuron_idx));
        end
        if (bus.acc_clr === 1'b1) begin
          have = q_clr.size(); ev.e = 0; ev.v = 0;
          if (have > 0) ev = q_clr.pop_front();
          match("acc_clr", have, ev, 0);
        end
      end
      prev_addr = int'(bus.feat_addr);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int cnt_for(input int v);
`ifdef NN_SEQ_STRICT_IDX_EN
    return v;
`else
    return (v >= 0) ? int'($urandom_range(255, 0)) : 0;
`endif
  endfunction

  task automatic idle_gap();
    int g;
    g = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
    bus.in_valid = 1'b0;
    bus.count    = AW'($urandom_range(255, 0));
    repeat (g) tick();
  endtask

  // Drives one beat; t returns the edge that samples it.
  task automatic send_beat(input int cnt, output int t);
    bus.in_valid = 1'b1;
    bus.count    = AW'(cnt);
    tick();
    bus.in_valid = 1'b0;
    t = cyc;
  endtask

  task automatic do_start(input bit with_beat);
    bus.start    = 1'b1;
    bus.in_valid = with_beat;
    bus.count    = '0;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    q_clr.push_back('{cyc, 0});
  endtask

  task automatic load_features(input bit inject_bad);
    int  t;
    ev_t ev;
    for (int j = 0; j < NIN; j++) begin
      idle_gap();
`ifdef NN_SEQ_STRICT_IDX_EN
      if (inject_bad && j == 5) begin
        send_beat(7, t);
        @(negedge clock);
        chk("strict_mismatch_err", int'(bus.err), 1);
      end
`endif
      send_beat(cnt_for(j), t);
      ev.e = t; ev.v = j;
      q_we.push_back(ev);
    end
  endtask

  // One neuron: NIN weight beats, optional stray beat in FLUSH, then wait until the next beat is allowed.
  task automatic run_neuron(input int n, input bit flush_beat);
    int  t;
    int  t2;
    ev_t ev;
    t = 0;
    for (int j = 0; j < NIN; j++) begin
      idle_gap();
      send_beat(cnt_for(j + 1), t);
      ev.e = t + 1; ev.v = j;
      q_mac.push_back(ev);
    end
    ev.e = t + DRAIN + 1; ev.v = n;
    q_nd.push_back(ev);
    if (n < NNEU - 1) begin
      ev.e = t + DRAIN + 2; ev.v = 0;
      q_clr.push_back(ev);
    end
    if (flush_beat) begin
      send_beat(cnt_for(NIN), t2);
      @(negedge clock);
      chk("flush_beat_err", int'(bus.err), 1);
    end
    while (cyc < t + DRAIN + 3) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_feat_we"},     int'(bus.feat_we), 0);
    chk({tag, "_feat_addr"},   int'(bus.feat_addr), 0);
    chk({tag, "_mac_en"},      int'(bus.mac_en), 0);
    chk({tag, "_acc_clr"},     int'(bus.acc_clr), 0);
    chk({tag, "_neuron_done"}, int'(bus.neuron_done), 0);
    chk({tag, "_neuron_idx"},  int'(bus.neuron_idx), 0);
    chk({tag, "_busy"},        int'(bus.busy), 0);
    chk({tag, "_done"},        int'(bus.done), 0);
    chk({tag, "_err"},         int'(bus.err), 0);
  endtask

  initial begin
    int t;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.count    = '0;
    repeat (3) tick();
    @(negedge clock);
    chk_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Beats in IDLE are ignored without error.
    repeat (4) send_beat(int'($urandom_range(255, 0)), t);
    @(negedge clock);
    chk("idle_beat_err", int'(bus.err), 0);
    chk("idle_busy", int'(bus.busy), 0);

    do_start(1'b0);
    @(negedge clock);
    chk("start_busy", int'(bus.busy), 1);
    load_features(1'b0);
    @(negedge clock);
    chk("load_err", int'(bus.err), 0);
    chk("load_busy", int'(bus.busy), 1);

    run_neuron(0, 1'b1);
    for (int n = 1; n < NNEU; n++) run_neuron(n, 1'b0);
    @(negedge clock);
    chk("run_done", int'(bus.done), 1);
    chk("run_busy", int'(bus.busy), 0);
    chk("run_err_sticky", int'(bus.err), 1);
    chk("run_nd_left", q_nd.size(), 0);

    // Restart from DONE with a coincident beat: start wins, err clears.
    do_start(1'b1);
    @(negedge clock);
    chk("restart_err", int'(bus.err), 0);
    chk("restart_done", int'(bus.done), 0);
    chk("restart_busy", int'(bus.busy), 1);
    load_features(1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clock);
    chk("start_while_busy_err", int'(bus.err), 1);
    chk("start_while_busy_busy", int'(bus.busy), 1);
    for (int n = 0; n < 3; n++) run_neuron(n, 1'b0);

    // Neuron 3: reset lands just after beat 20 is sampled.
    for (int j = 0; j <= 20; j++) begin
      ev_t ev;
      idle_gap();
      send_beat(cnt_for(j + 1), t);
      ev.e = t + 1; ev.v = j;
      q_mac.push_back(ev);
    end
    reset = 1'b1;
    #1;
    q_we.delete();
    q_mac.delete();
    q_nd.delete();
    q_clr.delete();
    chk_all_zero("async_reset");
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) send_beat(int'($urandom_range(255, 0)), t);
    @(negedge clock);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_done", int'(bus.done), 0);
    chk("post_reset_err", int'(bus.err), 0);

    do_start(1'b0);
    load_features(1'b0);
    repeat (4) tick();
    @(negedge clock);
    chk("final_err", int'(bus.err), 0);
    chk("final_we_left", q_we.size(), 0);
    chk("final_mac_left", q_mac.size(), 0);
    chk("final_nd_left", q_nd.size(), 0);
    chk("final_clr_left", q_clr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
